// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage fields into the forwarding/hazard controller; operand selects and pipeline controls out.
// STALL_CNT_EN adds the stall_count output.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  branch_taken;
  logic                  hold;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_bubble;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0]      stall_count;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, branch_taken, hold,
    input  fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, idex_bubble
`ifdef STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memread, branch_taken, hold,
    output fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, idex_bubble
`ifdef STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding mux selects and load-use / branch / memory-wait control for a 5-stage pipeline.
// Optional feature macro STALL_CNT_EN: saturating count of load-use stalls on stall_count.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
`ifdef STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } ex_stage_t;

  // MEM and WB only ever act as forwarding sources, so their operand fields are not kept.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
  } wr_stage_t;

  state_t    state_q, state_d;
  ex_stage_t ex_q, ex_d;
  wr_stage_t mem_q, mem_d;
  wr_stage_t wb_q, wb_d;

  logic lu;
  logic take_stall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;

  function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic [REG_ADDR_W-1:0] src,
                                         input wr_stage_t mem, input wr_stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_valid) begin
      if (mem.valid && mem.regwrite && (mem.dest != '0) && (mem.dest == src))
        sel = 2'b10;
      else if (wb.valid && wb.regwrite && (wb.dest != '0) && (wb.dest == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lu = ex_q.valid && ex_q.memread && (ex_q.dest != '0) && bus.id_valid &&
         ((ex_q.dest == bus.id_rs) || (ex_q.dest == bus.id_rt));
    // In STALL the load has already moved past EX, so lu needs no masking there beyond the state test.
    take_stall = (state_q == RUN) && lu && !bus.branch_taken && !bus.hold;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (bus.hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (take_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    state_d = state_q;
    if (!bus.hold)
      state_d = take_stall ? STALL : RUN;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!bus.hold) begin
      wb_d           = mem_q;
      mem_d.valid    = ex_q.valid;
      mem_d.dest     = ex_q.dest;
      mem_d.regwrite = ex_q.regwrite;
      ex_d.valid     = bus.id_valid && !idex_bubble;
      ex_d.rs        = bus.id_rs;
      ex_d.rt        = bus.id_rt;
      ex_d.dest      = bus.id_dest;
      ex_d.regwrite  = bus.id_regwrite;
      ex_d.memread   = bus.id_memread;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.fwd_a       = fwd_sel(ex_q.valid, ex_q.rs, mem_q, wb_q);
  assign bus.fwd_b       = fwd_sel(ex_q.valid, ex_q.rt, mem_q, wb_q);
  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take_stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign bus.stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl: per-cycle expected control words are queued as stimulus is driven
// and compared against the outputs at the following falling edge.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       br;
    logic       hd;
  } stim_t;

  // {fwd_a, fwd_b, pc_write, ifid_write, ifid_flush, idex_bubble}
  typedef logic [7:0] ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  ctl_t exp_q[$];

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] dest,
                               logic rw, logic mr, logic br, logic hd);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.dest = dest; s.rw = rw; s.mr = mr; s.br = br; s.hd = hd;
    return s;
  endfunction

  function automatic ctl_t ct(logic [1:0] fa, logic [1:0] fb, logic pcw, logic ifw, logic fl, logic bub);
    return {fa, fb, pcw, ifw, fl, bub};
  endfunction

  function automatic ctl_t obs();
    return {bus.fwd_a, bus.fwd_b, bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble};
  endfunction

  function automatic stim_t nop(logic br, logic hd);
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, br, hd);
  endfunction

  task automatic drive(input stim_t s);
    bus.id_valid     = s.v;
    bus.id_rs        = s.rs;
    bus.id_rt        = s.rt;
    bus.id_dest      = s.dest;
    bus.id_regwrite  = s.rw;
    bus.id_memread   = s.mr;
    bus.branch_taken = s.br;
    bus.hold         = s.hd;
  endtask

  task automatic apply_reset();
    drive(nop(1'b0, 1'b0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam ctl_t D = 8'b0000_1100;

  task automatic test_reset();
    ctl_t got;
    drive(nop(1'b0, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    got = obs();
    checks++;
    if (got !== D) begin errors++; $display("FAIL reset_outputs got=%b want=%b", got, D); end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.stall_count); end
`endif
    apply_reset();
  endtask

  task automatic test_ex_mem_fwd();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd3, 5'd1, 5'd4, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b10, 2'b00, 1, 1, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ex_mem_fwd[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wb_fwd();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(D);
    st.push_back(mk(1, 5'd1, 5'd3, 5'd5, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b00, 2'b01, 1, 1, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mem_wb_fwd[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd7, 5'd8, 5'd3, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd3, 5'd3, 5'd9, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b10, 2'b10, 1, 1, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL priority[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 1));
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b01, 2'b01, 1, 1, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count got=%0d want=1", bus.stall_count); end
`endif
  endtask

  task automatic test_branch_override();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 1, 0)); ex.push_back(ct(2'b00, 2'b00, 1, 1, 1, 1));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL branch[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL branch_count got=%0d want=0", bus.stall_count); end
`endif
  endtask

  task automatic test_r0();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd1, 5'd0, 5'd0, 1, 1, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL r0[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 1)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 0));
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 1)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 0));
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 1));
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b01, 2'b01, 1, 1, 0, 0));
    st.push_back(mk(1, 5'd1, 5'd1, 5'd7, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd7, 5'd1, 5'd8, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 1));                          ex.push_back(ct(2'b10, 2'b00, 0, 0, 0, 0));
    st.push_back(nop(1, 1));                          ex.push_back(ct(2'b10, 2'b00, 0, 0, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b10, 2'b00, 1, 1, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL hold[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL hold_count got=%0d want=1", bus.stall_count); end
`endif
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; ctl_t ex[$]; ctl_t got, want;
    apply_reset();
    st.push_back(mk(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 1));
    st.push_back(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(mk(1, 5'd1, 5'd0, 5'd3, 1, 1, 0, 0)); ex.push_back(ct(2'b01, 2'b01, 1, 1, 0, 0));
    st.push_back(mk(1, 5'd3, 5'd0, 5'd7, 1, 0, 0, 0)); ex.push_back(ct(2'b00, 2'b00, 0, 0, 0, 1));
    st.push_back(mk(1, 5'd3, 5'd0, 5'd7, 1, 0, 0, 0)); ex.push_back(D);
    st.push_back(nop(0, 0));                          ex.push_back(ct(2'b01, 2'b00, 1, 1, 0, 0));
    st.push_back(nop(0, 0));                          ex.push_back(D);
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want); end
      @(posedge clk); #1;
    end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL b2b_count got=%0d want=2", bus.stall_count); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    ctl_t got, want;
    apply_reset();
    drive(mk(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0));
    exp_q.push_back(ct(2'b00, 2'b00, 0, 0, 0, 1));
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mid_stall_entry got=%b want=%b", got, want); end
    @(posedge clk); #2;
    // Now in STALL with the load in MEM; the reset must clear it before any further clock.
    reset = 1'b1;
    #1;
    got = obs(); checks++;
    if (got !== D) begin errors++; $display("FAIL mid_stall_reset got=%b want=%b", got, D); end
`ifdef STALL_CNT_EN
    checks++;
    if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL mid_stall_count got=%0d want=0", bus.stall_count); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    drive(mk(1, 5'd2, 5'd2, 5'd6, 1, 0, 0, 0));
    @(posedge clk); #1;
    drive(nop(0, 0));
    exp_q.push_back(D);
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mid_stall_no_fwd got=%b want=%b", got, want); end
    @(posedge clk); #1;
  endtask

  initial begin
    drive(nop(1'b0, 1'b0));
    test_reset();
    test_ex_mem_fwd();
    test_mem_wb_fwd();
    test_priority();
    test_load_use();
    test_branch_override();
    test_r0();
    test_hold();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
